// File: rtl/tis_pkg.sv
// tis_pkg: port-select codes, link bit indices, ANY priority order and select helpers shared with the node core
package tis_pkg;
  localparam int DW = 11;
  localparam logic [2:0] SEL_UP = 3'd0, SEL_DOWN = 3'd1, SEL_LEFT = 3'd2, SEL_RIGHT = 3'd3;
  localparam logic [2:0] SEL_ANY = 3'd4, SEL_LAST = 3'd5, SEL_NIL = 3'd6;
  localparam int PORT_UP = 0, PORT_DOWN = 1, PORT_LEFT = 2, PORT_RIGHT = 3;
  localparam logic [7:0] ANY_ORDER = {2'(PORT_DOWN), 2'(PORT_UP), 2'(PORT_RIGHT), 2'(PORT_LEFT)};
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE} state_t;
  function automatic logic sel_nil(input logic [2:0] sel, input logic last_vld);
    return sel >= SEL_NIL || (sel == SEL_LAST && !last_vld);
  endfunction
  function automatic logic [3:0] sel_mask(input logic [2:0] sel, input logic [1:0] last_port);
    return sel == SEL_ANY ? 4'hf : sel == SEL_LAST ? 4'b1 << last_port : 4'b1 << sel[1:0];
  endfunction
endpackage

// File: rtl/tis_port_arbiter_if.sv
// tis_port_arbiter_if: four inbound and four outbound valid/ready neighbour links
interface tis_port_arbiter_if #(parameter int DW = tis_pkg::DW);
  logic [3:0] in_valid, in_rdy, out_valid, out_rdy;
  logic [4*DW-1:0] in_data;
  logic [DW-1:0] out_data;
  modport master (input in_valid, in_data, out_rdy, output in_rdy, out_valid, out_data);
  modport slave (output in_valid, in_data, out_rdy, input in_rdy, out_valid, out_data);
endinterface

// File: rtl/tis_prio_pick.sv
// tis_prio_pick: fixed-priority one-hot pick, LEFT > RIGHT > UP > DOWN, with the winning index
module tis_prio_pick import tis_pkg::*; (
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = 3; i >= 0; i--) if (req[ANY_ORDER[2*i +: 2]]) idx = ANY_ORDER[2*i +: 2];
    gnt = |req ? 4'b1 << idx : 4'b0;
  end
endmodule

// File: rtl/tis_port_arbiter.sv
// tis_port_arbiter: sequences execute-stage reads/writes onto the four neighbour links, resolving ANY/LAST/NIL
module tis_port_arbiter import tis_pkg::*; #(parameter int DW = tis_pkg::DW) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic [2:0]    rd_sel,
  output logic          rd_done,
  output logic [DW-1:0] rd_data,
  input  logic          wr_req,
  input  logic [2:0]    wr_sel,
  input  logic [DW-1:0] wr_data,
  output logic          wr_done,
  tis_port_arbiter_if.master link,
  output logic          last_vld,
  output logic [1:0]    last_port,
  output logic          busy
);
  state_t state, nxt;
  logic [3:0] mask, nxt_mask, rd_gnt, wr_gnt;
  logic [1:0] rd_idx, wr_idx;
  logic [2:0] sel;
  logic any, nxt_any, nil, rd_xfer, wr_xfer;
  tis_prio_pick u_rd_pick (.req(mask & link.in_valid), .gnt(rd_gnt), .idx(rd_idx));
  tis_prio_pick u_wr_pick (.req(mask & link.out_rdy), .gnt(wr_gnt), .idx(wr_idx));
  always_comb begin
    sel = rd_req ? rd_sel : wr_sel;
    nil = sel_nil(sel, last_vld);
    rd_xfer = state == RD_WAIT && rd_req && |rd_gnt;
    wr_xfer = state == WR_WAIT && wr_req && |wr_gnt;
    link.in_rdy = state == RD_WAIT && rd_req ? rd_gnt : 4'b0;
    link.out_valid = state == WR_WAIT && wr_req ? wr_gnt : 4'b0;
    link.out_data = wr_data;
    rd_done = state == RD_DONE;
    wr_done = state == WR_DONE;
    busy = state != IDLE;
    nxt = state;
    nxt_mask = mask;
    nxt_any = any;
    case (state)
      IDLE: if (rd_req || wr_req) begin
        nxt = rd_req ? (nil ? RD_DONE : RD_WAIT) : (nil ? WR_DONE : WR_WAIT);
        nxt_mask = sel_mask(sel, last_port);
        nxt_any = sel == SEL_ANY;
      end
      RD_WAIT: nxt = !rd_req ? IDLE : rd_xfer ? RD_DONE : RD_WAIT;
      WR_WAIT: nxt = !wr_req ? IDLE : wr_xfer ? WR_DONE : WR_WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mask <= '0;
      any <= 1'b0;
      rd_data <= '0;
      last_vld <= 1'b0;
      last_port <= '0;
    end else begin
      state <= nxt;
      mask <= nxt_mask;
      any <= nxt_any;
      if (state == IDLE && rd_req && nil) rd_data <= '0;
      if (rd_xfer) rd_data <= link.in_data[rd_idx*DW +: DW];
      if ((rd_xfer || wr_xfer) && any) begin
        last_vld <= 1'b1;
        last_port <= rd_xfer ? rd_idx : wr_idx;
      end
    end
endmodule

// File: tb/tb_tis_port_arbiter.sv
// tb_tis_port_arbiter: directed scenarios plus randomized reads/writes against a priority/LAST reference model
module tb_tis_port_arbiter;
  import tis_pkg::*;
  logic clk = 0, rst_n = 0, rd_req = 0, wr_req = 0;
  logic [2:0] rd_sel = 0, wr_sel = 0;
  logic [DW-1:0] wr_data = 0, rd_data;
  logic rd_done, wr_done, last_vld, busy;
  logic [1:0] last_port;
  int checks = 0, failures = 0, conflicts = 0;
  logic m_vld = 0;
  logic [1:0] m_port = 0;
  logic [DW-1:0] dvals [4];
  int cyc, act, acy, cyc2, act2, acy2;
  logic [3:0] seen, seen2;
  logic [DW-1:0] got, got2;
  tis_port_arbiter_if #(.DW(DW)) link();
  tis_port_arbiter #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_sel(rd_sel), .rd_done(rd_done), .rd_data(rd_data),
    .wr_req(wr_req), .wr_sel(wr_sel), .wr_data(wr_data), .wr_done(wr_done), .link(link.master),
    .last_vld(last_vld), .last_port(last_port), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if ((link.in_rdy & link.out_valid) != 4'b0) conflicts++;

  function automatic int pick(input logic [3:0] req);
    int order [4] = '{2, 3, 0, 1};
    for (int i = 0; i < 4; i++) if (req[order[i]]) return order[i];
    return -1;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] sel);
    if (sel < 3'd4) return 4'b1 << sel[1:0];
    if (sel == SEL_ANY) return 4'hf;
    if (sel == SEL_LAST && m_vld) return 4'b1 << m_port;
    return 4'b0;
  endfunction

  task automatic put(input int k, input logic [DW-1:0] v);
    dvals[k] = v;
    link.in_data[k*DW +: DW] = v;
  endtask

  task automatic run_rd(input logic [2:0] sel, output int c, output int a, output int ac,
                        output logic [3:0] s, output logic [DW-1:0] g);
    @(posedge clk); #1;
    rd_sel = sel; rd_req = 1; a = 0; ac = -1; s = 0;
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (link.in_rdy != 0) begin a++; ac = c; s |= link.in_rdy; end
      if (rd_done) break;
    end
    g = rd_data;
    @(posedge clk); #1;
    rd_req = 0;
  endtask

  task automatic run_wr(input logic [2:0] sel, input logic [DW-1:0] d, output int c, output int a,
                        output int ac, output logic [3:0] s, output logic [DW-1:0] g);
    @(posedge clk); #1;
    wr_sel = sel; wr_data = d; wr_req = 1; a = 0; ac = -1; s = 0; g = 0;
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (link.out_valid != 0) begin a++; ac = c; s |= link.out_valid; g = link.out_data; end
      if (wr_done) break;
    end
    @(posedge clk); #1;
    wr_req = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 0 || rd_done !== 0 || wr_done !== 0) begin failures++; $display("FAIL reset_ctl busy=%b rd_done=%b wr_done=%b exp 0", busy, rd_done, wr_done); end
    checks++; if (rd_data !== 0 || last_vld !== 0 || last_port !== 0) begin failures++; $display("FAIL reset_regs rd_data=%0d last_vld=%b last_port=%0d exp 0", rd_data, last_vld, last_port); end
    checks++; if (link.in_rdy !== 0 || link.out_valid !== 0) begin failures++; $display("FAIL reset_link in_rdy=%b out_valid=%b exp 0", link.in_rdy, link.out_valid); end
    rst_n = 1;
    m_vld = 0; m_port = 0;
  endtask

  task automatic test_nil;
    run_rd(SEL_NIL, cyc, act, acy, seen, got);
    checks++; if (cyc !== 1 || got !== 0 || act !== 0) begin failures++; $display("FAIL rd_nil cyc=%0d data=%0d act=%0d exp 1/0/0", cyc, got, act); end
    run_rd(SEL_LAST, cyc, act, acy, seen, got);
    checks++; if (cyc !== 1 || got !== 0 || act !== 0) begin failures++; $display("FAIL rd_last_unset cyc=%0d data=%0d act=%0d exp 1/0/0", cyc, got, act); end
    link.out_rdy = 4'hf;
    run_wr(SEL_NIL, 11'd33, cyc, act, acy, seen, got);
    checks++; if (cyc !== 1 || act !== 0) begin failures++; $display("FAIL wr_nil cyc=%0d act=%0d exp 1/0", cyc, act); end
    link.out_rdy = 0;
  endtask

  task automatic test_read_up;
    put(0, 11'd7); link.in_valid = 4'b0001;
    run_rd(SEL_UP, cyc, act, acy, seen, got);
    checks++; if (seen !== 4'b0001 || acy !== 1 || act !== 1) begin failures++; $display("FAIL up_rdy seen=%b cyc=%0d n=%0d exp 0001/1/1", seen, acy, act); end
    checks++; if (cyc !== 2 || got !== 11'd7) begin failures++; $display("FAIL up_done cyc=%0d data=%0d exp 2/7", cyc, got); end
    checks++; if (last_vld !== 0) begin failures++; $display("FAIL up_last last_vld=%b exp 0", last_vld); end
    link.in_valid = 0;
  endtask

  task automatic test_read_any_last;
    put(2, 11'd3); put(1, -11'sd5); link.in_valid = 4'b0110;
    run_rd(SEL_ANY, cyc, act, acy, seen, got);
    checks++; if (seen !== 4'b0100 || got !== 11'd3) begin failures++; $display("FAIL any_rd seen=%b data=%0d exp 0100/3", seen, got); end
    checks++; if (last_vld !== 1 || last_port !== 2'd2) begin failures++; $display("FAIL any_last vld=%b port=%0d exp 1/2", last_vld, last_port); end
    m_vld = 1; m_port = 2;
    link.in_valid = 4'b0000; put(2, 11'd9);
    fork
      run_rd(SEL_LAST, cyc, act, acy, seen, got);
      begin repeat (4) @(posedge clk); #1 link.in_valid = 4'b1111; end
    join
    checks++; if (seen !== 4'b0100 || got !== 11'd9 || acy !== 3) begin failures++; $display("FAIL last_rd seen=%b data=%0d cyc=%0d exp 0100/9/3", seen, got, acy); end
    link.in_valid = 0;
  endtask

  task automatic test_write_any;
    link.out_rdy = 0;
    fork
      run_wr(SEL_ANY, 11'd12, cyc, act, acy, seen, got);
      begin repeat (6) @(posedge clk); #1 link.out_rdy = 4'b1010; end
    join
    checks++; if (seen !== 4'b1000 || act !== 1 || acy !== 5) begin failures++; $display("FAIL wr_any seen=%b n=%0d cyc=%0d exp 1000/1/5", seen, act, acy); end
    checks++; if (got !== 11'd12 || cyc !== acy + 1) begin failures++; $display("FAIL wr_any_done data=%0d done_cyc=%0d exp 12/%0d", got, cyc, acy + 1); end
    checks++; if (last_vld !== 1 || last_port !== 2'd3) begin failures++; $display("FAIL wr_any_last vld=%b port=%0d exp 1/3", last_vld, last_port); end
    m_port = 3;
    link.out_rdy = 0;
  endtask

  task automatic test_simultaneous;
    put(3, 11'd100); link.in_valid = 4'b1000; link.out_rdy = 4'b0001;
    conflicts = 0;
    fork
      run_rd(SEL_RIGHT, cyc, act, acy, seen, got);
      run_wr(SEL_UP, 11'd55, cyc2, act2, acy2, seen2, got2);
    join
    checks++; if (cyc !== 2 || got !== 11'd100 || seen !== 4'b1000) begin failures++; $display("FAIL sim_rd cyc=%0d data=%0d seen=%b exp 2/100/1000", cyc, got, seen); end
    checks++; if (cyc2 !== 5 || acy2 !== 4 || seen2 !== 4'b0001 || got2 !== 11'd55) begin failures++; $display("FAIL sim_wr cyc=%0d act=%0d seen=%b data=%0d exp 5/4/0001/55", cyc2, acy2, seen2, got2); end
    checks++; if (conflicts !== 0) begin failures++; $display("FAIL sim_conflict count=%0d exp 0", conflicts); end
    link.in_valid = 0; link.out_rdy = 0;
  endtask

  task automatic test_abort;
    int dones;
    dones = 0;
    link.in_valid = 0;
    @(posedge clk); #1;
    rd_sel = SEL_UP; rd_req = 1;
    repeat (3) @(negedge clk);
    rd_req = 0;
    repeat (3) begin @(negedge clk); if (rd_done) dones++; end
    checks++; if (dones !== 0 || busy !== 0) begin failures++; $display("FAIL abort dones=%0d busy=%b exp 0/0", dones, busy); end
  endtask

  task automatic test_random;
    logic [2:0] sel;
    logic [3:0] v, m, es;
    logic is_rd;
    int p;
    for (int n = 0; n < 40; n++) begin
      sel = 3'($urandom_range(7));
      is_rd = 1'($urandom_range(1));
      v = 4'($urandom_range(15));
      for (int k = 0; k < 4; k++) put(k, DW'($urandom));
      m = ref_mask(sel);
      if ((m & v) == 0) v |= m;
      p = pick(m & v);
      es = p < 0 ? 4'b0 : 4'b1 << p;
      if (is_rd) begin
        link.in_valid = v;
        run_rd(sel, cyc, act, acy, seen, got);
        checks++; if (cyc !== (p < 0 ? 1 : 2) || seen !== es || got !== (p < 0 ? '0 : dvals[p < 0 ? 0 : p])) begin
          failures++; $display("FAIL rand_rd n=%0d sel=%0d cyc=%0d seen=%b data=%0d exp cyc=%0d seen=%b data=%0d", n, sel, cyc, seen, got, p < 0 ? 1 : 2, es, p < 0 ? 0 : dvals[p < 0 ? 0 : p]);
        end
      end else begin
        link.out_rdy = v;
        run_wr(sel, dvals[0], cyc, act, acy, seen, got);
        checks++; if (cyc !== (p < 0 ? 1 : 2) || seen !== es || (p >= 0 && got !== dvals[0])) begin
          failures++; $display("FAIL rand_wr n=%0d sel=%0d cyc=%0d seen=%b data=%0d exp cyc=%0d seen=%b data=%0d", n, sel, cyc, seen, got, p < 0 ? 1 : 2, es, dvals[0]);
        end
      end
      if (sel == SEL_ANY) begin m_vld = 1; m_port = 2'(p); end
      checks++; if (last_vld !== m_vld || (m_vld && last_port !== m_port)) begin
        failures++; $display("FAIL rand_last n=%0d vld=%b port=%0d exp %b/%0d", n, last_vld, last_port, m_vld, m_port);
      end
      link.in_valid = 0; link.out_rdy = 0;
    end
  endtask

  task automatic test_async_reset;
    int dones;
    dones = 0;
    put(1, 11'd21); link.in_valid = 4'b0010;
    @(posedge clk); #1;
    rd_sel = SEL_DOWN; rd_req = 1;
    repeat (2) @(negedge clk);
    checks++; if (link.in_rdy !== 4'b0010) begin failures++; $display("FAIL ares_pre in_rdy=%b exp 0010", link.in_rdy); end
    #1 rst_n = 0;
    #1;
    checks++; if (link.in_rdy !== 0 || busy !== 0 || rd_data !== 0 || last_vld !== 0) begin
      failures++; $display("FAIL ares_now in_rdy=%b busy=%b data=%0d vld=%b exp 0", link.in_rdy, busy, rd_data, last_vld);
    end
    rd_req = 0; link.in_valid = 0;
    repeat (2) begin @(negedge clk); if (rd_done) dones++; end
    rst_n = 1; m_vld = 0;
    repeat (2) begin @(negedge clk); if (rd_done) dones++; end
    checks++; if (dones !== 0 || rd_data !== 0 || last_vld !== 0 || busy !== 0) begin
      failures++; $display("FAIL ares_after dones=%0d data=%0d vld=%b busy=%b exp 0", dones, rd_data, last_vld, busy);
    end
  endtask

  initial begin
    link.in_valid = 0; link.in_data = 0; link.out_rdy = 0;
    test_reset;
    test_nil;
    test_read_up;
    test_read_any_last;
    test_write_any;
    test_simultaneous;
    test_abort;
    test_random;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
